fadd_accum_ctrl: RTL and testbench
==================================

# fadd_accum_ctrl

Sequential FP32 stream accumulator that drives the combinational single-precision adder. It accepts a stream of FP32 samples over a valid/ready handshake and presents the running sum and the next sample to the adder's `a`/`b` inputs. It registers the adder's `y` result as the new running sum and emits one FP32 total per frame downstream. It also bypasses the adder for zero operands, which the adder cannot handle because it always inserts the implicit 1.

## Interface

Parameters:
- `N_SAMPLES`, default 8: samples per frame. Legal range 1..255.
- `CNT_W`, default `$clog2(N_SAMPLES+1)`: width of the sample counter.

Ports:
- `clk`  in  1  : sole clock; all state updates on the rising edge.
- `rst`  in  1  : synchronous, active-high reset.
- `in_valid`  in  1  : `in_data` is valid.
- `in_ready`  out  1  : block can accept a sample this cycle.
- `in_data`  in  32  : FP32 sample.
- `in_last`  in  1  : sample closes the frame early; qualified by the handshake.
- `add_a`  out  32  : to adder `a`; equals the accumulator register.
- `add_b`  out  32  : to adder `b`; equals `in_data`.
- `add_y`  in  32  : from adder `y`; combinational function of `add_a`/`add_b`.
- `out_valid`  out  1  : frame sum available.
- `out_ready`  in  1  : downstream accepts the sum.
- `out_data`  out  32  : FP32 frame sum.
- `out_count`  out  `CNT_W`  : number of samples in the frame.

## Operation

- States:
  - `EMPTY`: accumulator holds no value.
  - `ACC`: accumulator holds a partial sum.
  - `DONE`: sum is being presented downstream.
- `in_ready` = (state != `DONE`).
- Accept = `in_valid && in_ready`.
- Zero test: sample is zero when `in_data[30:0] == 0`; both signs of zero count.
- On accept in `EMPTY`:
  - If the sample is non-zero, `acc <= in_data` and state → `ACC`.
  - If the sample is zero, `acc` stays `0x00000000` and state stays `EMPTY`.
  - In both cases `cnt <= cnt+1`.
- On accept in `ACC`:
  - If the sample is zero, `acc` is unchanged.
  - Otherwise `acc <= add_y`.
  - In both cases `cnt <= cnt+1`.
- Frame close: an accepted sample with `in_last==1` or `cnt+1 == N_SAMPLES` moves the state to `DONE`. The accumulator update for that sample still applies.
- In `DONE`:
  - `out_valid=1`, `out_data=acc`, `out_count=cnt`.
  - When `out_ready==1`: `acc<=0`, `cnt<=0`, state → `EMPTY`.
- An all-zero frame returns `0x00000000`.
- `out_data` is whatever the adder produces; this block performs no rounding or normalization.

## Timing

- Reset values:
  - `acc=0x00000000`, `cnt=0`, state `EMPTY`.
  - `out_valid=0`, `out_data=0x00000000`, `out_count=0`, `in_ready=1`.
  - `add_a=0x00000000`.
- Throughput: one sample per cycle while not in `DONE`.
- Latency: `out_valid` rises on the edge that accepts the closing sample and is visible the following cycle.
- The cycle in which `out_valid && out_ready` fires accepts no input, because `in_ready=0` in `DONE`. The next frame's first sample is accepted the cycle after. Frame bubble is therefore 1 cycle minimum.
- `out_data` and `out_count` are held stable while `out_valid && !out_ready`.
- Reset mid-frame discards the partial sum and count. The in-flight sample is dropped.
- Critical path: `acc` → adder → `acc` mux, single cycle.

## Configuration

- Macro: `FADD_ACCUM_OVF_FLAG_EN`.
- Defined:
  - Adds output `out_ovf` (1 bit).
  - Sticky per frame: set when an adder-path update writes `acc[30:23]==8'hFF`.
  - Presented with `out_valid`.
  - Cleared on output handshake and on `rst`.
  - Reset value 0.
- Undefined: port and logic are absent. Behaviour is otherwise identical.

## Structure

- Shared package `fp32_pkg`:
  - Constants `FP32_ZERO`, `FP32_EXP_MSB=30`, `FP32_EXP_LSB=23`, `FP32_EXP_MAX=8'hFF`.
  - `typedef enum {EMPTY, ACC, DONE} facc_state_t`.
- One natural sub-module, `fp32_classify`: combinational `is_zero`/`is_inf_or_nan` from a 32-bit word. It is shared with other stages that feed the adder.
- The adder is instantiated by the parent, not inside this block.

## Test plan

- Reset, then 8 × `0x3F800000` (1.0) back-to-back with `out_ready=1`:
  - `out_data=0x41000000` (8.0), `out_count=8`.
  - `out_valid` is high for exactly 1 cycle, in the cycle after the 8th accept.
- Samples 1.0, 2.0, 3.0 with `in_last` on the third: `out_data=0x40C00000` (6.0), `out_count=3`.
- Zero bypass, sequence `0x00000000`, `0x80000000`, `0x40000000`, `in_last`:
  - `out_data=0x40000000`, `out_count=3`.
  - `add_y` is ignored while the accumulator is `EMPTY`.
- Backpressure: hold `out_ready=0` for 5 cycles after `DONE`:
  - `in_ready=0` and `out_data` stable for those cycles.
  - The handshake on cycle 6 returns the block to `EMPTY` with `in_ready=1`.
- Reset asserted after 3 of 8 samples:
  - All outputs return to reset values.
  - A following 8 × 1.0 frame yields `0x41000000`.
- With `FADD_ACCUM_OVF_FLAG_EN`:
  - Samples `0x7F000000`, `0x7F000000` raise `out_ovf=1` alongside `out_valid`.
  - The next frame of 1.0s reports `out_ovf=0`.

Source files
------------

// File: rtl/fp32_pkg.sv
// fp32_pkg
// Shared FP32 field constants and the accumulator controller state type.
// Imported by fp32_classify and fadd_accum_ctrl.
//   FP32_ZERO              : positive zero bit pattern
//   FP32_EXP_MSB/LSB       : exponent field bit positions
//   FP32_EXP_MAX           : all-ones exponent (Inf/NaN)
//   facc_state_t           : EMPTY / ACC / DONE
//   fp32_exp()             : extracts the biased exponent field
package fp32_pkg;

    localparam logic [31:0] FP32_ZERO    = 32'h0000_0000;
    localparam int          FP32_EXP_MSB = 30;
    localparam int          FP32_EXP_LSB = 23;
    localparam logic [7:0]  FP32_EXP_MAX = 8'hFF;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ACC   = 2'd1,
        DONE  = 2'd2
    } facc_state_t;

    function automatic logic [7:0] fp32_exp(input logic [31:0] word);
        return word[FP32_EXP_MSB:FP32_EXP_LSB];
    endfunction

endpackage

// File: rtl/fp32_classify.sv
// fp32_classify
// Combinational classification of one FP32 word, shared by every stage that
// feeds the single-precision adder.
// Ports:
//   word_i          in  32 : FP32 word to classify
//   is_zero_o       out 1  : +0 or -0 (magnitude bits all zero)
//   is_inf_or_nan_o out 1  : exponent field all ones
module fp32_classify
    import fp32_pkg::*;
(
    input  logic [31:0] word_i,
    output logic        is_zero_o,
    output logic        is_inf_or_nan_o
);

    // Sign does not participate in either test.
    logic unused_sign;
    assign unused_sign = word_i[31];

    assign is_zero_o       = (word_i[30:0] == 31'd0);
    assign is_inf_or_nan_o = (fp32_exp(word_i) == FP32_EXP_MAX);

endmodule

// File: rtl/fadd_accum_ctrl.sv
// fadd_accum_ctrl
// Sequential FP32 stream accumulator wrapped around an external combinational
// FP32 adder. The running sum is presented on add_a, the incoming sample on
// add_b, and add_y is registered back as the new sum. Zero samples bypass the
// adder because the adder always inserts the implicit leading one. One total
// per frame is emitted on a valid/ready output.
// Optional feature macro: FADD_ACCUM_OVF_FLAG_EN adds out_ovf, a per-frame
// sticky flag set when an adder-path update writes an all-ones exponent.
// Ports:
//   clk, rst                        : clock, synchronous active-high reset
//   in_valid/in_ready/in_data/in_last : sample stream (in_last closes early)
//   add_a/add_b/add_y               : to/from the combinational adder
//   out_valid/out_ready             : frame-sum handshake
//   out_data/out_count              : frame sum and number of samples
//   out_ovf (macro only)            : overflow seen during the frame
module fadd_accum_ctrl
    import fp32_pkg::*;
#(
    parameter int N_SAMPLES = 8,
    parameter int CNT_W     = $clog2(N_SAMPLES + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic             in_last,
    output logic [31:0]      add_a,
    output logic [31:0]      add_b,
    input  logic [31:0]      add_y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [CNT_W-1:0] out_count
`ifdef FADD_ACCUM_OVF_FLAG_EN
    ,
    output logic             out_ovf
`endif
);

    facc_state_t      state_q, state_d;
    logic [31:0]      acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_valid_q, out_valid_d;
    logic             in_ready_q, in_ready_d;
`ifdef FADD_ACCUM_OVF_FLAG_EN
    logic             ovf_q, ovf_d;
`endif

    // Classify the incoming sample (index 0) and the adder result (index 1).
    logic [31:0] cls_word [2];
    logic [1:0]  zero_vec;
    logic [1:0]  special_vec;

    assign cls_word[0] = in_data;
    assign cls_word[1] = add_y;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cls
            fp32_classify u_cls (
                .word_i          (cls_word[gi]),
                .is_zero_o       (zero_vec[gi]),
                .is_inf_or_nan_o (special_vec[gi])
            );
        end
    endgenerate

    // Only the sample's zero flag and the result's special flag matter here.
    logic unused_cls;
    assign unused_cls = ^{zero_vec[1], special_vec};

    logic             sample_zero;
    logic             accept;
    logic             frame_close;
    logic [CNT_W-1:0] cnt_inc;

    assign sample_zero = zero_vec[0];
    assign accept      = in_valid && in_ready_q;
    assign cnt_inc     = cnt_q + CNT_W'(1);
    assign frame_close = in_last || (cnt_inc == CNT_W'(N_SAMPLES));

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
`ifdef FADD_ACCUM_OVF_FLAG_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    cnt_d = cnt_inc;
                    // First non-zero sample loads directly; the adder would
                    // treat the empty (zero) accumulator as 1.0 x 2^-127.
                    if (!sample_zero) begin
                        acc_d   = in_data;
                        state_d = ACC;
                    end
                    if (frame_close) begin
                        state_d = DONE;
                    end
                end
            end
            ACC: begin
                if (accept) begin
                    cnt_d = cnt_inc;
                    if (!sample_zero) begin
                        acc_d = add_y;
`ifdef FADD_ACCUM_OVF_FLAG_EN
                        if (special_vec[1]) begin
                            ovf_d = 1'b1;
                        end
`endif
                    end
                    if (frame_close) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    acc_d   = FP32_ZERO;
                    cnt_d   = '0;
                    state_d = EMPTY;
`ifdef FADD_ACCUM_OVF_FLAG_EN
                    ovf_d   = 1'b0;
`endif
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
        // Handshake outputs are registered copies of the next state.
        out_valid_d = (state_d == DONE);
        in_ready_d  = (state_d != DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= EMPTY;
            acc_q       <= FP32_ZERO;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
`ifdef FADD_ACCUM_OVF_FLAG_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
`ifdef FADD_ACCUM_OVF_FLAG_EN
            ovf_q       <= ovf_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign add_a     = acc_q;
    assign add_b     = in_data;
    assign out_valid = out_valid_q;
    assign out_data  = acc_q;
    assign out_count = cnt_q;
`ifdef FADD_ACCUM_OVF_FLAG_EN
    assign out_ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_fadd_accum_ctrl.sv
// tb_fadd_accum_ctrl
// Randomized and directed stimulus for fadd_accum_ctrl. A behavioural FP32
// adder (via IEEE double arithmetic) sits on add_a/add_b/add_y. The driver
// pushes each frame's expected sum into a scoreboard queue; a separate
// monitor pops and compares whenever out_valid is presented.
// Honours FADD_ACCUM_OVF_FLAG_EN for the out_ovf port and overflow case.
module tb_fadd_accum_ctrl;

    localparam int N = 8;
    localparam real OVF_LIMIT = 3.402823669209385e38; // 2^128

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = 32'h0;
    logic        in_last = 1'b0;
    logic [31:0] add_a, add_b, add_y;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic [3:0]  out_count;
`ifdef FADD_ACCUM_OVF_FLAG_EN
    logic        out_ovf;
`endif

    always #5 clk = ~clk;

    fadd_accum_ctrl #(.N_SAMPLES(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_y     (add_y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count)
`ifdef FADD_ACCUM_OVF_FLAG_EN
        ,
        .out_ovf   (out_ovf)
`endif
    );

    // ---------------- FP32 <-> real helpers (normals, zero, Inf) ----------
    function automatic real fp_to_real(input logic [31:0] f);
        int          e;
        logic [10:0] de;
        e = int'(f[30:23]);
        if (e == 0) return $bitstoreal({f[31], 63'd0});
        if (e == 255) return $bitstoreal({f[31], 11'h7FF, f[22:0], 29'd0});
        de = 11'(e - 127 + 1023);
        return $bitstoreal({f[31], de, f[22:0], 29'd0});
    endfunction

    function automatic logic [31:0] real_to_fp(input real r);
        logic [63:0] b;
        int          e;
        b = $realtobits(r);
        e = int'(b[62:52]);
        if (e == 0) return {b[63], 31'd0};
        if (e == 2047) return {b[63], 8'hFF, b[51:29]};
        e = e - 1023 + 127;
        if (e >= 255) return {b[63], 8'hFF, 23'd0};
        if (e <= 0) return {b[63], 31'd0};
        return {b[63], e[7:0], b[51:29]};
    endfunction

    // Behavioural adder standing in for the external combinational unit.
    always_comb add_y = real_to_fp(fp_to_real(add_a) + fp_to_real(add_b));

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [31:0] data;
        logic [3:0]  cnt;
        logic        ovf;
        int          hold;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   bench_hold = 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Frame model: plain real-valued sum of the non-zero samples.
    real m_sum = 0.0;
    int  m_cnt = 0;
    bit  m_seen = 0;
    bit  m_ovf = 0;

    task automatic model_reset();
        m_sum = 0.0; m_cnt = 0; m_seen = 0; m_ovf = 0;
    endtask

    task automatic model_accept(input logic [31:0] d, input logic last);
        exp_t e;
        m_cnt++;
        if (d[30:0] != 31'd0) begin
            if (m_seen) begin
                m_sum = m_sum + fp_to_real(d);
                if (m_sum >= OVF_LIMIT || m_sum <= -OVF_LIMIT) m_ovf = 1;
            end else begin
                m_sum  = fp_to_real(d);
                m_seen = 1;
            end
        end
        if (last || m_cnt == N) begin
            e.data = real_to_fp(m_sum);
            e.cnt  = 4'(m_cnt);
            e.ovf  = m_ovf;
            e.hold = bench_hold;
            sb.push_back(e);
            $display("frame expected: sum=%h count=%0d", e.data, m_cnt);
            model_reset();
        end
    endtask

    task automatic send(input logic [31:0] d, input logic last);
        int t;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        t = 0;
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) chk("in_ready_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        model_accept(d, last);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    function automatic logic [31:0] int_to_fp(input int v);
        return real_to_fp(real'(v));
    endfunction

    // ---------------- monitor ----------------
    bit mon_active = 0;

    initial begin
        exp_t cur;
        int   cycles;
        cycles = 0;
        cur.data = '0; cur.cnt = '0; cur.ovf = 1'b0; cur.hold = 1;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                mon_active = 0;
            end else if (out_valid) begin
                if (!mon_active) begin
                    mon_active = 1;
                    cycles = 0;
                    if (sb.size() == 0) begin
                        chk("unexpected_out_valid", 32'(out_valid), 32'd0);
                        cur.data = out_data; cur.cnt = out_count;
                        cur.ovf = 1'b0; cur.hold = 0;
                    end else begin
                        cur = sb.pop_front();
                        $display("frame observed: sum=%h count=%0d", out_data, out_count);
                        chk("out_data", out_data, cur.data);
                        chk("out_count", 32'(out_count), 32'(cur.cnt));
`ifdef FADD_ACCUM_OVF_FLAG_EN
                        chk("out_ovf", 32'(out_ovf), 32'(cur.ovf));
`endif
                    end
                end else begin
                    chk("out_data_held", out_data, cur.data);
                    chk("out_count_held", 32'(out_count), 32'(cur.cnt));
                end
                cycles++;
                if (out_ready) begin
                    if (cur.hold > 0) chk("valid_cycles", 32'(cycles), 32'(cur.hold));
                    mon_active = 0;
                end
            end
        end
    end

    // ---------------- driver ----------------
    initial begin
        int t;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, 32'h0);
        chk("rst_out_count", 32'(out_count), 32'd0);
        chk("rst_add_a", add_a, 32'h0);
        rst = 1'b0;

        // 8 x 1.0 back to back, closed by the sample count.
        for (int k = 0; k < N; k++) send(32'h3F80_0000, 1'b0);
        idle();
        chk("latency_out_valid", 32'(out_valid), 32'd1);
        chk("eight_ones_sum", out_data, 32'h4100_0000);
        chk("done_in_ready", 32'(in_ready), 32'd0);

        // 1.0, 2.0, 3.0 with early close.
        send(32'h3F80_0000, 1'b0);
        send(32'h4000_0000, 1'b0);
        send(32'h4040_0000, 1'b1);
        idle();
        chk("six_sum", out_data, 32'h40C0_0000);

        // Zero bypass with both zero signs.
        send(32'h0000_0000, 1'b0);
        send(32'h8000_0000, 1'b0);
        send(32'h4000_0000, 1'b1);
        idle();
        chk("zero_bypass_sum", out_data, 32'h4000_0000);

        // All-zero frame.
        send(32'h8000_0000, 1'b0);
        send(32'h0000_0000, 1'b1);
        idle();
        chk("all_zero_sum", out_data, 32'h0000_0000);

        // Backpressure: out_ready low for 5 presented cycles.
        @(negedge clk);
        out_ready  = 1'b0;
        bench_hold = 6;
        send(32'h4000_0000, 1'b0);
        send(32'h4040_0000, 1'b1);
        bench_hold = 1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            in_valid = 1'b0;
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_out_data", out_data, 32'h40A0_0000);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_in_ready", 32'(in_ready), 32'd1);
        chk("bp_release_out_valid", 32'(out_valid), 32'd0);

        // Reset after 3 of 8 samples; in-flight sample dropped.
        for (int k = 0; k < 3; k++) send(32'h3F80_0000, 1'b0);
        @(negedge clk);
        rst      = 1'b1;
        in_data  = 32'h3F80_0000;
        @(negedge clk);
        in_valid = 1'b0;
        model_reset();
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_out_count", 32'(out_count), 32'd0);
        chk("mid_rst_out_data", out_data, 32'h0);
        chk("mid_rst_add_a", add_a, 32'h0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;
        for (int k = 0; k < N; k++) send(32'h3F80_0000, 1'b0);
        idle();
        chk("post_rst_sum", out_data, 32'h4100_0000);

`ifdef FADD_ACCUM_OVF_FLAG_EN
        send(32'h7F00_0000, 1'b0);
        send(32'h7F00_0000, 1'b1);
        idle();
        chk("ovf_flag", 32'(out_ovf), 32'd1);
`endif

        // Randomized frames: small integers (exact in FP32), ~25% zeros,
        // random idle gaps, random early close.
        for (int f = 0; f < 30; f++) begin
            int len;
            len = $urandom_range(1, N);
            for (int k = 0; k < len; k++) begin
                logic [31:0] d;
                logic        last;
                int          v;
                if ($urandom_range(0, 3) == 0) begin
                    d = {1'($urandom_range(0, 1)), 31'd0};
                end else begin
                    v = $urandom_range(1, 100);
                    if ($urandom_range(0, 1) == 1) v = -v;
                    d = int_to_fp(v);
                end
                last = (k == len - 1) && (len < N || $urandom_range(0, 1) == 1);
                if ($urandom_range(0, 3) == 0) idle();
                send(d, last);
            end
            idle();
        end

        t = 0;
        while ((sb.size() != 0 || mon_active) && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running, want finished");
        $fatal(1, "timeout");
    end

endmodule
